// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - shared cve2 types: multdiv operator and MAC responder states
package cve2_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    ADD  = 2'b10,
    HOLD = 2'b11
  } mac_resp_state_e;

endpackage

// File: rtl/cve2_mac_sat_add.sv
// rtl/cve2_mac_sat_add.sv - combinational accumulate adder; signed saturation when CVE2_MAC_SAT_EN is defined
module cve2_mac_sat_add #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] raw_sum;

  assign raw_sum = a_i + b_i;

`ifdef CVE2_MAC_SAT_EN
  logic ovf;

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf = (a_i[Width-1] == b_i[Width-1]) && (raw_sum[Width-1] != a_i[Width-1]);

  always_comb begin
    sum_o = raw_sum;
    if (ovf) begin
      sum_o = a_i[Width-1] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end
  end
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/cve2_mac_resp_unit.sv
// rtl/cve2_mac_resp_unit.sv - MAC responder: drives the shared multiplier, accumulates, returns result
// Saturating accumulate is selected by CVE2_MAC_SAT_EN.
module cve2_mac_resp_unit
  import cve2_pkg::*;
#(
  parameter int unsigned Width      = 32,
  parameter int unsigned MulTimeout = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mac_req_i,
  input  logic [Width-1:0] mac_op_a_i,
  input  logic [Width-1:0] mac_op_b_i,
  input  logic [Width-1:0] mac_acc_i,
  input  logic             flush_i,
  output logic             mac_busy_o,
  output logic             mul_en_o,
  output md_op_e           mul_operator_o,
  output logic [Width-1:0] mul_op_a_o,
  output logic [Width-1:0] mul_op_b_o,
  input  logic [Width-1:0] mul_result_i,
  input  logic             mul_valid_i,
  output logic [Width-1:0] result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             err_timeout_o
);

  localparam int unsigned CntW = (MulTimeout > 2) ? $clog2(MulTimeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MulTimeout - 1);

  mac_resp_state_e  state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] a_q, b_q, acc_q, prod_q, result_q;
  logic [Width-1:0] sum;
  logic             load_ops, load_prod, load_res, timeout;

  cve2_mac_sat_add #(
    .Width (Width)
  ) u_sat_add (
    .a_i   (prod_q),
    .b_i   (acc_q),
    .sum_o (sum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_ops  = 1'b0;
    load_prod = 1'b0;
    load_res  = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mac_req_i) begin
          load_ops = 1'b1;
          cnt_d    = '0;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mul_valid_i) begin
          load_prod = 1'b1;
          state_d   = ADD;
        end else if (cnt_q == CntLast) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ADD: begin
        load_res = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides every other event, including a timeout in the same cycle.
    if (flush_i) begin
      state_d   = IDLE;
      load_ops  = 1'b0;
      load_prod = 1'b0;
      load_res  = 1'b0;
      timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_ops) begin
        a_q   <= mac_op_a_i;
        b_q   <= mac_op_b_i;
        acc_q <= mac_acc_i;
      end
      if (load_prod) begin
        prod_q <= mul_result_i;
      end
      if (load_res) begin
        result_q <= sum;
      end
    end
  end

  assign mac_busy_o     = (state_q != IDLE);
  assign mul_en_o       = (state_q == MUL);
  assign mul_operator_o = MD_OP_MULL;
  assign mul_op_a_o     = a_q;
  assign mul_op_b_o     = b_q;
  assign result_o       = result_q;
  assign result_valid_o = (state_q == HOLD);
  assign err_timeout_o  = timeout;

endmodule
